// File: rtl/regwb_pkg.sv
// regwb_pkg: shared widths and the write-back source select for reg_writeback_ctrl.
package regwb_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_LSU} src_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO buffering {rd, data} LSU results; sync active-low reset.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_wr, w_rd;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_din;
  end
endmodule

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: register-file write port arbiter (ALU vs buffered LSU), busy scoreboard, forwarding.
// REGWB_ALU_STALL_EN: a full LSU FIFO takes the slot from the ALU and raises alu_stall.
module reg_writeback_ctrl import regwb_pkg::*; #(
  parameter int LSU_DEPTH = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rd,
  output logic                issue_ready,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_stall,
  input  logic                lsu_valid,
  input  logic [ADDR_W-1:0]   lsu_rd,
  input  logic [DATA_W-1:0]   lsu_data,
  output logic                lsu_ready,
  output logic                regwrite,
  output logic [ADDR_W-1:0]   write_reg,
  output logic [DATA_W-1:0]   write_data,
  output logic [NUM_REGS-1:0] busy,
  input  logic [ADDR_W-1:0]   read_reg1,
  input  logic [ADDR_W-1:0]   read_reg2,
  output logic                fwd1_hit,
  output logic                fwd2_hit,
  output logic [DATA_W-1:0]   fwd1_data,
  output logic [DATA_W-1:0]   fwd2_data
);
  localparam int CW = $clog2(LSU_DEPTH) + 1;
  logic                     w_full, w_empty, w_push, w_pop, w_we;
  logic [CW-1:0]            w_cnt;
  logic [ADDR_W+DATA_W-1:0] w_head;
  logic [ADDR_W-1:0]        w_head_rd, w_rd;
  logic [DATA_W-1:0]        w_head_data, w_data;
  logic [NUM_REGS-1:0]      w_set, w_clr, r_busy;
  logic                     r_regwrite;
  logic [ADDR_W-1:0]        r_write_reg;
  logic [DATA_W-1:0]        r_write_data;
  src_e                     w_sel;
  wb_fifo #(.DEPTH(LSU_DEPTH), .W(ADDR_W + DATA_W)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_din  ({lsu_rd, lsu_data}),
    .o_dout (w_head),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(w_cnt)
  );
  // Ready is forced low while reset is held so nothing is accepted into a FIFO being cleared.
  assign lsu_ready = reset && !w_full;
  assign w_push    = lsu_valid && lsu_ready;
`ifdef REGWB_ALU_STALL_EN
  assign alu_stall = alu_valid && w_full;
`else
  assign alu_stall = 1'b0;
`endif
  assign w_head_rd   = w_head[ADDR_W+DATA_W-1 -: ADDR_W];
  assign w_head_data = w_head[DATA_W-1:0];
  assign w_sel  = (alu_valid && !alu_stall) ? SRC_ALU : (w_cnt != '0) ? SRC_LSU : SRC_NONE;
  assign w_pop  = (w_sel == SRC_LSU) && !w_empty;
  assign w_rd   = (w_sel == SRC_ALU) ? alu_rd : w_head_rd;
  assign w_data = (w_sel == SRC_ALU) ? alu_data : w_head_data;
  assign w_we   = (w_sel != SRC_NONE) && (w_rd != '0);
  assign issue_ready = !r_busy[issue_rd];
  assign w_set = (issue_valid && issue_ready && issue_rd != '0) ? NUM_REGS'(1) << issue_rd : '0;
  assign w_clr = w_pop ? NUM_REGS'(1) << w_head_rd : '0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_regwrite   <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_busy       <= '0;
    end else begin
      r_regwrite <= w_we;
      if (w_we) begin
        r_write_reg  <= w_rd;
        r_write_data <= w_data;
      end
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~NUM_REGS'(1);
    end
  end
  assign regwrite   = r_regwrite;
  assign write_reg  = r_write_reg;
  assign write_data = r_write_data;
  assign busy       = r_busy;
  assign fwd1_hit   = r_regwrite && (r_write_reg == read_reg1) && (read_reg1 != '0);
  assign fwd2_hit   = r_regwrite && (r_write_reg == read_reg2) && (read_reg2 != '0);
  assign fwd1_data  = r_write_data;
  assign fwd2_data  = r_write_data;
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb_reg_writeback_ctrl: directed self-checking bench for reg_writeback_ctrl.
module tb_reg_writeback_ctrl;
`ifdef REGWB_ALU_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif
  logic        clk = 1'b0, reset = 1'b0;
  logic        issue_valid = 1'b0, issue_ready;
  logic [4:0]  issue_rd = '0;
  logic        alu_valid = 1'b0, alu_stall;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0, lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        regwrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data, busy;
  logic [4:0]  read_reg1 = '0, read_reg2 = '0;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
  int n_chk = 0, n_pass = 0;
  reg_writeback_ctrl dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data), .busy(busy),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
    tick(); tick();
    check("rst_lsu_ready", lsu_ready, 0);
    check("rst_regwrite", regwrite, 0);
    check("rst_busy", busy, 0);
    check("rst_wdata", write_data, 0);
    check("rst_stall", alu_stall, 0);
    reset = 1'b1; lsu_valid = 1'b0;
    #1 check("rel_lsu_ready", lsu_ready, 1);
    tick();
    check("rel_no_write", regwrite, 0);
    // ALU write and forwarding
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0; read_reg1 = 5'd5; read_reg2 = 5'd6;
    #1;
    check("alu_regwrite", regwrite, 1);
    check("alu_wreg", write_reg, 5);
    check("alu_wdata", write_data, 32'hDEADBEEF);
    check("fwd1_hit", fwd1_hit, 1);
    check("fwd1_data", fwd1_data, 32'hDEADBEEF);
    check("fwd2_miss", fwd2_hit, 0);
    tick();
    check("idle_regwrite", regwrite, 0);
    check("fwd1_idle", fwd1_hit, 0);
    // Scoreboard set, blocked reissue, LSU write-back clears
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1 check("issue_ready7", issue_ready, 1);
    tick();
    check("busy7_set", busy, 32'h80);
    #1 check("issue_blocked", issue_ready, 0);
    tick();
    issue_valid = 1'b0;
    check("busy7_hold", busy, 32'h80);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1234;
    tick();
    lsu_valid = 1'b0;
    check("lsu_not_yet", regwrite, 0);
    tick();
    check("lsu_regwrite", regwrite, 1);
    check("lsu_wreg", write_reg, 7);
    check("lsu_wdata", write_data, 32'h1234);
    check("busy7_clr", busy, 0);
    // FIFO fill while ALU is continuously valid
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0;
    for (int i = 0; i < 6; i++) begin
      lsu_valid = (i < 4); lsu_rd = 5'(11 + i); lsu_data = 32'h100 + i;
      #1;
      if (i == 4) begin
        check("full_ready", lsu_ready, 0);
        check("full_stall", alu_stall, STALL);
      end
      tick();
      check($sformatf("fill_we%0d", i), regwrite, 1);
      check($sformatf("fill_wreg%0d", i), write_reg, (STALL && i == 4) ? 11 : 10);
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    for (int r = (STALL ? 12 : 11); r <= 14; r++) begin
      tick();
      check($sformatf("drain_wreg%0d", r), write_reg, r);
      check($sformatf("drain_wdata%0d", r), write_data, 32'h100 + (r - 11));
    end
    tick();
    check("drain_done", regwrite, 0);
    // rd==0 winners consume the slot without writing
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    tick();
    alu_valid = 1'b0;
    check("alu_r0_we", regwrite, 0);
    check("alu_r0_hold", write_data, 32'h103);
    issue_valid = 1'b1; issue_rd = 5'd20;
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h55;
    tick();
    issue_valid = 1'b0; lsu_valid = 1'b0;
    check("busy20", busy, 32'h0010_0000);
    tick();
    check("lsu_r0_we", regwrite, 0);
    check("lsu_r0_busy", busy, 32'h0010_0000);
    tick();
    check("lsu_r0_popped", regwrite, 0);
    // Same-cycle clear and set of busy[9]: set wins
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    tick();
    lsu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd9;
    #1 check("issue_ready9", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    check("r9_wreg", write_reg, 9);
    check("r9_busy", busy, 32'h0010_0200);
    // Reset mid-transfer drops buffered LSU results
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd22; lsu_data = 32'h22;
    tick(); tick();
    reset = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_busy", busy, 0);
    tick();
    check("midrst_dropped", regwrite, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
